mult_share_arbiter_taint: RTL and testbench

- Two-requester arbiter and sequencer that shares one bitwise taint-tracked sequential multiplier (WIDTH-bit operands, 2*WIDTH-bit product) between two client ports.
- Grants round-robin, latches the winner's operands, pulses the multiplier start, waits for done, then returns the product to the winner.
- Propagates shadow taint on every control and data output, including taint from the grant decision.
- Sits between client logic and the multiplier top level; the multiplier ports connect 1:1 to `mul_*`.

---
 rtl/mult_share_arbiter_taint.sv | 206 ++++++++++++++++++++
 tb/tb_mult_share_arbiter_taint.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter_taint.sv
// Two-client round-robin arbiter and sequencer sharing one taint-tracked sequential
// multiplier; every control and data output carries shadow taint, including grant-decision taint.
module mult_share_arbiter_taint #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req0_t,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a0_t,
    input  logic [WIDTH-1:0]   b0_t,
    input  logic               req1,
    input  logic               req1_t,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    input  logic [WIDTH-1:0]   a1_t,
    input  logic [WIDTH-1:0]   b1_t,
    output logic               ack0,
    output logic               ack0_t,
    output logic               ack1,
    output logic               ack1_t,
    output logic [2*WIDTH-1:0] result,
    output logic [2*WIDTH-1:0] result_t,
    output logic               err,
    output logic               err_t,
    output logic               mul_start,
    output logic               mul_start_t,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic [WIDTH-1:0]   mul_a_t,
    output logic [WIDTH-1:0]   mul_b_t,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic [2*WIDTH-1:0] mul_product_t,
    input  logic               mul_done,
    input  logic               mul_done_t
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state, state_nxt;
    logic              rr_ptr, rr_ptr_nxt;
    logic              winner, winner_nxt;
    logic              g_t, g_t_nxt;
    logic [CW-1:0]     wdog, wdog_nxt;
    logic [WIDTH-1:0]  mul_a_nxt, mul_b_nxt, mul_a_t_nxt, mul_b_t_nxt;
    logic [PW-1:0]     result_nxt, result_t_nxt;
    logic              ack0_nxt, ack0_t_nxt, ack1_nxt, ack1_t_nxt;
    logic              err_nxt, err_t_nxt;
    logic              mul_start_nxt, mul_start_t_nxt;

    // Grant choice and taint of the wait-exit decision
    logic              grant;
    logic              exit_t;
    logic              timed_out;

    always_comb begin
        grant     = (req0 && req1) ? rr_ptr : req1;
        exit_t    = g_t | mul_done_t;
        timed_out = (wdog == CW'(TIMEOUT - 1));
    end

    // Next-state and next-output logic; outputs are registered, so pulses are
    // raised on the transition into the state they belong to.
    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        winner_nxt      = winner;
        g_t_nxt         = g_t;
        wdog_nxt        = wdog;
        mul_a_nxt       = mul_a;
        mul_b_nxt       = mul_b;
        mul_a_t_nxt     = mul_a_t;
        mul_b_t_nxt     = mul_b_t;
        result_nxt      = result;
        result_t_nxt    = result_t;
        ack0_nxt        = 1'b0;
        ack0_t_nxt      = 1'b0;
        ack1_nxt        = 1'b0;
        ack1_t_nxt      = 1'b0;
        err_nxt         = 1'b0;
        err_t_nxt       = 1'b0;
        mul_start_nxt   = 1'b0;
        mul_start_t_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        rr_ptr_nxt = ~grant;
                    end
                    winner_nxt      = grant;
                    g_t_nxt         = req0_t | req1_t;
                    mul_a_nxt       = grant ? a1   : a0;
                    mul_b_nxt       = grant ? b1   : b0;
                    mul_a_t_nxt     = grant ? a1_t : a0_t;
                    mul_b_t_nxt     = grant ? b1_t : b0_t;
                    mul_start_nxt   = 1'b1;
                    mul_start_t_nxt = req0_t | req1_t;
                    state_nxt       = S_START;
                end
            end

            S_START: begin
                state_nxt = S_ARM;
            end

            // mul_done may still be high from the previous operation here
            S_ARM: begin
                wdog_nxt  = '0;
                state_nxt = S_WAIT;
            end

            S_WAIT: begin
                if (mul_done || timed_out) begin
                    if (mul_done) begin
                        result_nxt   = mul_product;
                        result_t_nxt = mul_product_t | {PW{exit_t}};
                    end else begin
                        result_nxt   = '0;
                        result_t_nxt = {PW{1'b1}};
                        err_nxt      = 1'b1;
                    end
                    err_t_nxt = exit_t;
                    if (winner) begin
                        ack1_nxt   = 1'b1;
                        ack1_t_nxt = exit_t;
                        ack0_t_nxt = g_t;
                    end else begin
                        ack0_nxt   = 1'b1;
                        ack0_t_nxt = exit_t;
                        ack1_t_nxt = g_t;
                    end
                    state_nxt = S_RESP;
                end else begin
                    wdog_nxt = wdog + CW'(1);
                end
            end

            S_RESP: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= 1'b0;
            winner      <= 1'b0;
            g_t         <= 1'b0;
            wdog        <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_a_t     <= '0;
            mul_b_t     <= '0;
            result      <= '0;
            result_t    <= '0;
            ack0        <= 1'b0;
            ack0_t      <= 1'b0;
            ack1        <= 1'b0;
            ack1_t      <= 1'b0;
            err         <= 1'b0;
            err_t       <= 1'b0;
            mul_start   <= 1'b0;
            mul_start_t <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            winner      <= winner_nxt;
            g_t         <= g_t_nxt;
            wdog        <= wdog_nxt;
            mul_a       <= mul_a_nxt;
            mul_b       <= mul_b_nxt;
            mul_a_t     <= mul_a_t_nxt;
            mul_b_t     <= mul_b_t_nxt;
            result      <= result_nxt;
            result_t    <= result_t_nxt;
            ack0        <= ack0_nxt;
            ack0_t      <= ack0_t_nxt;
            ack1        <= ack1_nxt;
            ack1_t      <= ack1_t_nxt;
            err         <= err_nxt;
            err_t       <= err_t_nxt;
            mul_start   <= mul_start_nxt;
            mul_start_t <= mul_start_t_nxt;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter_taint.sv
// Scoreboard bench for mult_share_arbiter_taint with a behavioural latency-3 multiplier
// whose product taint is {a_t, b_t} and whose done flag stays high until the next ARM ends.
module tb_mult_share_arbiter_taint;

    localparam int unsigned W   = 4;
    localparam int unsigned PW  = 8;
    localparam int unsigned TO  = 64;
    localparam int          LAT = 3;

    logic clk = 1'b0;
    logic rst;
    logic req0, req0_t, req1, req1_t;
    logic [W-1:0] a0, b0, a0_t, b0_t, a1, b1, a1_t, b1_t;
    logic ack0, ack0_t, ack1, ack1_t, err, err_t, mul_start, mul_start_t;
    logic [PW-1:0] result, result_t, mul_product, mul_product_t;
    logic [W-1:0] mul_a, mul_b, mul_a_t, mul_b_t;
    logic mul_done, mul_done_t;

    always #5 clk = ~clk;

    mult_share_arbiter_taint #(.WIDTH(W), .TIMEOUT(TO), .CW(7)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req0_t(req0_t), .a0(a0), .b0(b0), .a0_t(a0_t), .b0_t(b0_t),
        .req1(req1), .req1_t(req1_t), .a1(a1), .b1(b1), .a1_t(a1_t), .b1_t(b1_t),
        .ack0(ack0), .ack0_t(ack0_t), .ack1(ack1), .ack1_t(ack1_t),
        .result(result), .result_t(result_t), .err(err), .err_t(err_t),
        .mul_start(mul_start), .mul_start_t(mul_start_t),
        .mul_a(mul_a), .mul_b(mul_b), .mul_a_t(mul_a_t), .mul_b_t(mul_b_t),
        .mul_product(mul_product), .mul_product_t(mul_product_t),
        .mul_done(mul_done), .mul_done_t(mul_done_t)
    );

    // Behavioural multiplier; hang keeps done low to force a timeout
    logic hang;
    int   cnt;
    logic [W-1:0] la, lb, lat_t, lbt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 0; mul_done <= 1'b0; mul_product <= '0; mul_product_t <= '0;
            la <= '0; lb <= '0; lat_t <= '0; lbt <= '0;
        end else if (mul_start) begin
            cnt <= LAT; la <= mul_a; lb <= mul_b; lat_t <= mul_a_t; lbt <= mul_b_t;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1 && !hang) begin
                mul_done      <= 1'b1;
                mul_product   <= {4'b0, la} * {4'b0, lb};
                mul_product_t <= {lat_t, lbt};
            end else begin
                mul_done <= 1'b0;
            end
        end
    end

    typedef struct {
        logic       win;
        logic [7:0] res;
        logic [7:0] res_t;
        logic       ack_t;
        logic       oth_t;
        logic       err;
        logic       err_t;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int checks = 0, failures = 0, ack_count = 0, start_cycles = 0, cyc = 0, start_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic win, input logic [7:0] res, input logic [7:0] res_t,
                                input logic ack_t, input logic oth_t, input logic er,
                                input logic er_t, input int lat);
        exp_t x;
        x.win = win; x.res = res; x.res_t = res_t; x.ack_t = ack_t; x.oth_t = oth_t;
        x.err = er; x.err_t = er_t; x.lat = lat;
        return x;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expectation per ack pulse
    always @(negedge clk) begin
        if (mul_start) begin
            start_cycles++;
            start_cyc = cyc;
        end
        if (ack0 || ack1) begin
            ack_count++;
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {30'b0, ack1, ack0}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("ack0", 32'(ack0), 32'(!e.win));
                chk("ack1", 32'(ack1), 32'(e.win));
                chk("ack_t", 32'(e.win ? ack1_t : ack0_t), 32'(e.ack_t));
                chk("other_ack_t", 32'(e.win ? ack0_t : ack1_t), 32'(e.oth_t));
                chk("result", 32'(result), 32'(e.res));
                chk("result_t", 32'(result_t), 32'(e.res_t));
                chk("err", 32'(err), 32'(e.err));
                chk("err_t", 32'(err_t), 32'(e.err_t));
                chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
            end
        end
    end

    task automatic wait_acks(input int target, input int budget);
        int n;
        n = 0;
        while (ack_count < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ack_arrival", 32'(ack_count), 32'(target));
    endtask

    task automatic op(input logic c, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] at, input logic [W-1:0] bt,
                      input logic rt0, input logic rt1, input exp_t x, input bit withdraw);
        int base;
        int n;
        base = ack_count;
        sbq.push_back(x);
        req0_t = rt0; req1_t = rt1;
        if (!c) begin a0 = a; b0 = b; a0_t = at; b0_t = bt; req0 = 1'b1; end
        else    begin a1 = a; b1 = b; a1_t = at; b1_t = bt; req1 = 1'b1; end
        if (withdraw) begin
            n = 0;
            while (!mul_start && n < 20) begin @(negedge clk); #1; n++; end
            req0 = 1'b0; req1 = 1'b0;
            a1 = '0; b1 = '0;
        end
        wait_acks(base + 1, 200);
        req0 = 1'b0; req1 = 1'b0; req0_t = 1'b0; req1_t = 1'b0;
        a0_t = '0; b0_t = '0; a1_t = '0; b1_t = '0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int n;
        rst = 1'b1; hang = 1'b0; mul_done_t = 1'b0;
        req0 = 0; req0_t = 0; req1 = 0; req1_t = 0;
        a0 = 0; b0 = 0; a0_t = 0; b0_t = 0; a1 = 0; b1 = 0; a1_t = 0; b1_t = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {26'b0, ack0, ack0_t, ack1, ack1_t, err, mul_start}, 32'd0);
        chk("rst_result", {16'b0, result, result_t}, 32'd0);
        chk("rst_operands", {16'b0, mul_a, mul_b, mul_a_t, mul_b_t}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single client 0
        op(1'b0, 4'd3, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, mk(1'b0, 8'd15, 8'h00, 0, 0, 0, 0, 5), 1'b0);

        // Both held: grants 0,1,0
        base = ack_count;
        sbq.push_back(mk(1'b0, 8'd14, 8'h00, 0, 0, 0, 0, 5));
        sbq.push_back(mk(1'b1, 8'd16, 8'h00, 0, 0, 0, 0, 5));
        sbq.push_back(mk(1'b0, 8'd14, 8'h00, 0, 0, 0, 0, 5));
        a0 = 4'd2; b0 = 4'd7; a1 = 4'd4; b1 = 4'd4;
        req0 = 1'b1; req1 = 1'b1;
        wait_acks(base + 3, 300);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // Operand taint flows through the multiplier's product taint
        op(1'b1, 4'd9, 4'd9, 4'b0001, 4'd0, 1'b0, 1'b0, mk(1'b1, 8'd81, 8'h10, 0, 0, 0, 0, 5), 1'b0);
        // Tainted grant decision saturates result and control taint
        op(1'b1, 4'd9, 4'd9, 4'b0001, 4'd0, 1'b1, 1'b0, mk(1'b1, 8'd81, 8'hFF, 1, 1, 0, 1, 5), 1'b0);

        // Timeout abort
        hang = 1'b1;
        op(1'b0, 4'd3, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, mk(1'b0, 8'd0, 8'hFF, 0, 0, 1, 0, TO + 2), 1'b0);
        hang = 1'b0;

        // Withdrawn request still completes; then max operands
        op(1'b1, 4'd6, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, mk(1'b1, 8'd42, 8'h00, 0, 0, 0, 0, 5), 1'b1);
        op(1'b0, 4'd15, 4'd15, 4'd0, 4'd0, 1'b0, 1'b0, mk(1'b0, 8'd225, 8'h00, 0, 0, 0, 0, 5), 1'b0);

        // Asynchronous reset during WAIT
        hang = 1'b1;
        a0 = 4'd2; b0 = 4'd2; req0 = 1'b1;
        n = 0;
        while (!mul_start && n < 20) begin @(negedge clk); #1; n++; end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", {26'b0, ack0, ack0_t, ack1, ack1_t, err, mul_start}, 32'd0);
        chk("midrst_result", {16'b0, result, result_t}, 32'd0);
        chk("midrst_operands", {16'b0, mul_a, mul_b, mul_a_t, mul_b_t}, 32'd0);
        req0 = 1'b0; hang = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // After reset both request: client 0 wins first
        base = ack_count;
        sbq.push_back(mk(1'b0, 8'd2, 8'h00, 0, 0, 0, 0, 5));
        sbq.push_back(mk(1'b1, 8'd9, 8'h00, 0, 0, 0, 0, 5));
        a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd3;
        req0 = 1'b1; req1 = 1'b1;
        wait_acks(base + 2, 200);
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);

        chk("mul_start_cycles", 32'(start_cycles), 32'd12);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
